// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - LD/ST arbiter for the shared data-memory port
// Optional feature macro DMEM_TIMEOUT_EN adds an access watchdog and timeout_err.
module dmem_port_arbiter #(
  parameter int MAX_LD_STREAK  = 4
`ifdef DMEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  output logic        ld_ack,
  output logic [31:0] ld_rdata,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic [1:0]  st_size,
  output logic        st_ack,
  output logic [31:0] data_address_2DM,
  output logic [31:0] data_write_2DM,
  output logic [1:0]  data_write_size_2DM,
  output logic        MemRead_2DM,
  output logic        MemWrite_2DM,
  input  logic [31:0] data_read_fDM,
  input  logic        data_valid_fDM,
`ifdef DMEM_TIMEOUT_EN
  output logic        timeout_err,
`endif
  output logic        busy
);

  localparam int SW = $clog2(MAX_LD_STREAK + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [SW-1:0]   r_streak;
  logic            r_is_st;
  logic            w_grant_ld;
  logic            w_grant_st;
  logic            w_finish;
  logic            w_unused;

  // Loads are always fetched word-aligned, so the byte offset is dropped.
  assign w_unused = ^ld_addr[1:0];

`ifdef DMEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]   r_tmo_cnt;
  logic            w_timeout;
`endif

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_grant_ld   = 1'b0;
    w_grant_st   = 1'b0;
    w_finish     = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    w_timeout    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (st_req && (!ld_req || (r_streak >= SW'(MAX_LD_STREAK)))) begin
          w_grant_st   = 1'b1;
          w_next_state = S_ACCESS;
        end else if (ld_req) begin
          w_grant_ld   = 1'b1;
          w_next_state = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (data_valid_fDM) begin
          w_finish     = 1'b1;
          w_next_state = S_DONE;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          w_timeout    = 1'b1;
          w_next_state = S_DONE;
        end
`endif
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_streak            <= '0;
      r_is_st             <= 1'b0;
      ld_ack              <= 1'b0;
      st_ack              <= 1'b0;
      ld_rdata            <= '0;
      data_address_2DM    <= '0;
      data_write_2DM      <= '0;
      data_write_size_2DM <= '0;
      MemRead_2DM         <= 1'b0;
      MemWrite_2DM        <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      r_tmo_cnt           <= '0;
      timeout_err         <= 1'b0;
`endif
    end else begin
      ld_ack <= 1'b0;
      st_ack <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      timeout_err <= 1'b0;
      if (w_grant_ld || w_grant_st) r_tmo_cnt <= '0;
      else if (r_state == S_ACCESS) r_tmo_cnt <= r_tmo_cnt + TW'(1);
`endif
      if (w_grant_ld) begin
        r_is_st             <= 1'b0;
        data_address_2DM    <= {ld_addr[31:2], 2'b00};
        data_write_2DM      <= '0;
        data_write_size_2DM <= 2'd0;
        MemRead_2DM         <= 1'b1;
        // Only a load that overtakes a waiting store counts toward starvation.
        if (!st_req)                          r_streak <= '0;
        else if (r_streak < SW'(MAX_LD_STREAK)) r_streak <= r_streak + SW'(1);
      end
      if (w_grant_st) begin
        r_is_st             <= 1'b1;
        data_address_2DM    <= st_addr;
        data_write_2DM      <= st_wdata;
        data_write_size_2DM <= st_size;
        MemWrite_2DM        <= 1'b1;
        r_streak            <= '0;
      end
      if (w_finish) begin
        MemRead_2DM  <= 1'b0;
        MemWrite_2DM <= 1'b0;
        ld_ack       <= ~r_is_st;
        st_ack       <= r_is_st;
        if (!r_is_st) ld_rdata <= data_read_fDM;
      end
`ifdef DMEM_TIMEOUT_EN
      if (w_timeout) begin
        MemRead_2DM  <= 1'b0;
        MemWrite_2DM <= 1'b0;
        ld_ack       <= ~r_is_st;
        st_ack       <= r_is_st;
        timeout_err  <= 1'b1;
        if (!r_is_st) ld_rdata <= 32'hDEAD_DEAD;
      end
`endif
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - randomized self-checking bench for dmem_port_arbiter
// Timestamp-based transaction model; DMEM_TIMEOUT_EN enables the watchdog checks.
module tb_dmem_port_arbiter;

  localparam int MAX_LD_STREAK = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic        ld_ack;
  logic [31:0] ld_rdata;
  logic        st_req;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [1:0]  st_size;
  logic        st_ack;
  logic [31:0] data_address_2DM;
  logic [31:0] data_write_2DM;
  logic [1:0]  data_write_size_2DM;
  logic        MemRead_2DM;
  logic        MemWrite_2DM;
  logic [31:0] data_read_fDM;
  logic        data_valid_fDM;
  logic        busy;
`ifdef DMEM_TIMEOUT_EN
  logic        timeout_err;
`endif

`ifdef DMEM_TIMEOUT_EN
  dmem_port_arbiter #(.MAX_LD_STREAK(MAX_LD_STREAK), .TIMEOUT_CYCLES(8)) dut (
`else
  dmem_port_arbiter #(.MAX_LD_STREAK(MAX_LD_STREAK)) dut (
`endif
    .CLK(CLK), .RESET(RESET),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .st_req(st_req), .st_addr(st_addr), .st_wdata(st_wdata), .st_size(st_size),
    .st_ack(st_ack),
    .data_address_2DM(data_address_2DM), .data_write_2DM(data_write_2DM),
    .data_write_size_2DM(data_write_size_2DM),
    .MemRead_2DM(MemRead_2DM), .MemWrite_2DM(MemWrite_2DM),
    .data_read_fDM(data_read_fDM), .data_valid_fDM(data_valid_fDM),
`ifdef DMEM_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Transaction model: grant edge m_g, latency m_L, ack on edge m_g+m_L.
  logic        m_have = 1'b0;
  int          m_g, m_L, m_free_at, m_streak;
  logic        m_st;
  logic [31:0] m_addr, m_wdata, m_cap, m_rdata;
  logic [1:0]  m_size;
  int          ld_ack_at = -10;
  int          st_ack_at = -10;

  int          mode = 2;
  int          force_lat = 0;
  logic        force_data_en = 1'b0;
  logic [31:0] force_data = '0;
  logic        rec = 1'b0;
  int          ack_q[$];
  int          st_ack_cnt = 0;
  logic [31:0] last_rd_addr = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic want_req();
    if (mode == 0) return ($urandom_range(0, 2) == 0);
    return (mode == 1);
  endfunction

  task automatic check_outputs();
    logic acc, ackc, bsy;
    acc  = m_have && (cyc >= m_g) && (cyc <= m_g + m_L - 1);
    ackc = m_have && (cyc == m_g + m_L);
    bsy  = m_have && (cyc >= m_g) && (cyc <= m_g + m_L);
    if (ackc && !m_st) begin m_rdata = m_cap; ld_ack_at = cyc; end
    if (ackc && m_st)  st_ack_at = cyc;
    if (MemRead_2DM) last_rd_addr = data_address_2DM;
    if (st_ack) st_ack_cnt++;
    if (rec && ld_ack) ack_q.push_back(0);
    if (rec && st_ack) ack_q.push_back(1);
    check("MemRead_2DM", 32'(MemRead_2DM), 32'(acc && !m_st));
    check("MemWrite_2DM", 32'(MemWrite_2DM), 32'(acc && m_st));
    if (acc) begin
      check("port_addr", data_address_2DM, m_addr);
      check("port_size", 32'(data_write_size_2DM), 32'(m_size));
      if (m_st) check("port_wdata", data_write_2DM, m_wdata);
    end
    check("ld_ack", 32'(ld_ack), 32'(ackc && !m_st));
    check("st_ack", 32'(st_ack), 32'(ackc && m_st));
    check("ack_exclusive", 32'(ld_ack & st_ack), 32'd0);
    check("busy", 32'(busy), 32'(bsy));
    check("ld_rdata", ld_rdata, m_rdata);
`ifdef DMEM_TIMEOUT_EN
    check("timeout_err", 32'(timeout_err), 32'd0);
`endif
  endtask

  task automatic step();
    logic in_prog, hit;
    check_outputs();
    if (!ld_req || cyc == ld_ack_at + 1) begin
      ld_req = want_req();
      if (ld_req) ld_addr = $urandom();
    end
    if (!st_req || cyc == st_ack_at + 1) begin
      st_req = want_req();
      if (st_req) begin
        st_addr  = $urandom();
        st_wdata = $urandom();
        st_size  = 2'($urandom_range(0, 3));
      end
    end
    in_prog = m_have && (cyc >= m_g) && (cyc <= m_g + m_L - 2);
    hit     = m_have && (cyc == m_g + m_L - 1);
    data_read_fDM = force_data_en ? force_data : $urandom();
    if (hit) begin
      data_valid_fDM = 1'b1;
      m_cap = data_read_fDM;
    end else if (in_prog) data_valid_fDM = 1'b0;
    else data_valid_fDM = ($urandom_range(0, 3) == 0);
    if ((cyc + 1 >= m_free_at) && (ld_req || st_req)) begin
      m_st = st_req && (!ld_req || m_streak >= MAX_LD_STREAK);
      if (m_st) begin
        m_streak = 0;
        m_addr   = st_addr;
        m_wdata  = st_wdata;
        m_size   = st_size;
      end else begin
        m_streak = st_req ? ((m_streak < MAX_LD_STREAK) ? m_streak + 1 : m_streak) : 0;
        m_addr   = ld_addr & 32'hFFFF_FFFC;
        m_size   = 2'd0;
      end
      m_have    = 1'b1;
      m_g       = cyc + 1;
      m_L       = (force_lat != 0) ? force_lat : $urandom_range(1, 6);
      m_free_at = m_g + m_L + 2;
    end
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
  endtask

  task automatic model_reset();
    m_have    = 1'b0;
    m_free_at = cyc + 1;
    m_streak  = 0;
    m_rdata   = '0;
    ld_ack_at = -10;
    st_ack_at = -10;
  endtask

  initial begin
    int pat[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    RESET = 1'b1; ld_req = 1'b1; ld_addr = 32'h0000_1003;
    st_req = 1'b0; st_addr = '0; st_wdata = '0; st_size = '0;
    data_read_fDM = '0; data_valid_fDM = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_MemRead", 32'(MemRead_2DM), 32'd0);
    check("rst_MemWrite", 32'(MemWrite_2DM), 32'd0);
    check("rst_ld_ack", 32'(ld_ack), 32'd0);
    check("rst_st_ack", 32'(st_ack), 32'd0);
    check("rst_ld_rdata", ld_rdata, 32'd0);
    check("rst_addr", data_address_2DM, 32'd0);
    check("rst_wdata", data_write_2DM, 32'd0);
    check("rst_size", 32'(data_write_size_2DM), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Single load, 1-cycle hit, request held through reset.
    RESET = 1'b0; cyc = 0; model_reset();
    mode = 2; force_lat = 1; force_data_en = 1'b1; force_data = 32'hA5A5_0001;
    repeat (6) step();
    check("single_ld_rdata", ld_rdata, 32'hA5A5_0001);
    check("single_ld_addr", last_rd_addr, 32'h0000_1000);
    force_data_en = 1'b0;

    // Store with a 5-cycle miss.
    st_req = 1'b1; st_addr = 32'h0000_2002; st_size = 2'd2; st_wdata = 32'h0000_BEEF;
    force_lat = 5; st_ack_cnt = 0;
    repeat (10) step();
    check("store_ack_count", 32'(st_ack_cnt), 32'd1);

    // Both requesters saturating the port.
    mode = 1; force_lat = 1; rec = 1'b1;
    repeat (40) step();
    rec = 1'b0; mode = 2; force_lat = 0;
    repeat (25) step();
    check("grant_order_len", 32'(ack_q.size() >= 10), 32'd1);
    for (int i = 0; i < 10 && i < ack_q.size(); i++)
      check("grant_order", 32'(ack_q[i]), 32'(pat[i]));

    mode = 0;
    repeat (600) step();
    mode = 2;
    repeat (25) step();

    // Reset in the middle of a long load.
    ld_req = 1'b1; ld_addr = $urandom(); force_lat = 6;
    repeat (3) step();
    RESET = 1'b1; data_valid_fDM = 1'b0;
    @(posedge CLK); cyc++; @(negedge CLK);
    check("midrst_MemRead", 32'(MemRead_2DM), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ld_ack", 32'(ld_ack), 32'd0);
    RESET = 1'b0; ld_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); cyc++; @(negedge CLK);
      check("midrst_no_ack", 32'(ld_ack | st_ack | MemRead_2DM), 32'd0);
    end

`ifdef DMEM_TIMEOUT_EN
    begin
      int seen, n;
      ld_req = 1'b1; ld_addr = 32'h0000_3001; data_valid_fDM = 1'b0;
      seen = 0;
      for (int i = 0; i < 5 && seen == 0; i++) begin
        @(posedge CLK); cyc++; @(negedge CLK);
        if (MemRead_2DM) seen = 1;
      end
      check("tmo_start", 32'(seen), 32'd1);
      n = seen;
      while (MemRead_2DM && n < 20) begin
        check("tmo_err_early", 32'(timeout_err), 32'd0);
        @(posedge CLK); cyc++; @(negedge CLK);
        if (MemRead_2DM) n++;
      end
      check("tmo_len", 32'(n), 32'd8);
      check("tmo_ld_ack", 32'(ld_ack), 32'd1);
      check("tmo_err", 32'(timeout_err), 32'd1);
      check("tmo_rdata", ld_rdata, 32'hDEAD_DEAD);
      ld_req = 1'b0;
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
